// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions: FSM state encoding, parity-mode codes,
//             per-frame configuration record and baud divisor helper.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Frame FSM states (kept as plain constants so legacy code can compare them)
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Parity-mode codes; 2'b11 is treated like PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Frame options captured together with a word
    typedef struct packed {
        logic [1:0] parity_mode;
        logic       two_stop;
    } frame_cfg_t;

    // Clock cycles per bit (integer division, caller guarantees result >= 4)
    function automatic int uart_div(input int f_osc, input int baud_rate);
        return f_osc / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ext_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ext_if
//  Purpose  : Producer-side bundle of the UART transmitter: valid/ready word
//             handshake, frame options and the line/status outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_ext_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [1:0]           parity_mode;
    logic                 two_stop;
    logic                 busy;
    logic                 txd;

    // Producer side
    modport master (
        output tx_data, tx_valid, parity_mode, two_stop,
        input  tx_ready, busy, txd
    );

    // Transmitter side
    modport slave (
        input  tx_data, tx_valid, parity_mode, two_stop,
        output tx_ready, busy, txd
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_gen
//  Purpose  : Bit-period down-counter. Counts DIV-1 .. 0 while enabled and
//             flags a tick on 0; restart reloads so a new bit gets full DIV.
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic en,
    output logic tick
);
    localparam int            CW     = $clog2(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Down-counter with synchronous restart and wrap back to DIV-1 on tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= RELOAD;
        end else if (en) begin
            if (r_cnt == '0) begin
                r_cnt <= RELOAD;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign tick = en && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ext.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_ext
//  Purpose  : UART transmitter with one-entry holding register, optional
//             even/odd parity and one or two stop bits. A pending word is
//             loaded straight out of the last stop bit, giving gap-free
//             back-to-back frames.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_ext
    import uart_pkg::*;
#(
    parameter int F_OSC     = 12_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    uart_tx_ext_if.slave bus
);
    localparam int            DIV      = uart_div(F_OSC, BAUD_RATE);
    localparam int            BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    // Holding register
    logic                 r_hold_full;
    logic [DATA_BITS-1:0] r_hold_data;
    frame_cfg_t           r_hold_cfg;

    // Frame in flight
    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_two_stop;
    logic                 r_stop_second;

    logic w_tick;
    logic w_transfer;
    logic w_stop_done;
    logic w_load;
    logic w_txd;

    assign w_transfer  = bus.tx_valid && !r_hold_full;
    assign w_stop_done = (r_state == STOP) && w_tick && (!r_two_stop || r_stop_second);
    // A pending word starts from IDLE or directly at the end of the stop period
    assign w_load      = r_hold_full && ((r_state == IDLE) || w_stop_done);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (w_load),
        .en      (r_state != IDLE),
        .tick    (w_tick)
    );

    // Holding register: filled on handshake, drained when a frame is loaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_cfg  <= '0;
        end else if (w_transfer) begin
            r_hold_full          <= 1'b1;
            r_hold_data          <= bus.tx_data;
            r_hold_cfg.parity_mode <= bus.parity_mode;
            r_hold_cfg.two_stop    <= bus.two_stop;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // Frame sequencer: loads a frame, then advances one bit per baud tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_par_en      <= 1'b0;
            r_par_bit     <= 1'b0;
            r_two_stop    <= 1'b0;
            r_stop_second <= 1'b0;
        end else if (w_load) begin
            r_state       <= START;
            r_shift       <= r_hold_data;
            r_bit_cnt     <= '0;
            r_par_en      <= (r_hold_cfg.parity_mode == PAR_EVEN) ||
                             (r_hold_cfg.parity_mode == PAR_ODD);
            r_par_bit     <= (r_hold_cfg.parity_mode == PAR_ODD) ? ~^r_hold_data
                                                                 :  ^r_hold_data;
            r_two_stop    <= r_hold_cfg.two_stop;
            r_stop_second <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                START: begin
                    r_state <= DATA;
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_state <= r_par_en ? PARITY : STOP;
                    end else begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                end
                PARITY: begin
                    r_state <= STOP;
                end
                STOP: begin
                    if (r_two_stop && !r_stop_second) begin
                        r_stop_second <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Line level from the current state; idle and stop bits are high
    always_comb begin
        w_txd = 1'b1;
        case (r_state)
            START:   w_txd = 1'b0;
            DATA:    w_txd = r_shift[0];
            PARITY:  w_txd = r_par_bit;
            default: w_txd = 1'b1;
        endcase
    end

    assign bus.txd      = w_txd;
    assign bus.busy     = (r_state != IDLE);
    assign bus.tx_ready = !r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_ext
//  Purpose  : Directed and randomized frames on an 8-bit and a 7-bit
//             transmitter, checked cycle by cycle against a bit-list model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_ext;

    localparam int         DIV      = 12;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    bit   exp_q[$];

    uart_tx_ext_if #(.DATA_BITS(8)) if8 ();
    uart_tx_ext_if #(.DATA_BITS(7)) if7 ();

    uart_tx_ext #(.F_OSC(1_200_000), .BAUD_RATE(100_000), .DATA_BITS(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    uart_tx_ext #(.F_OSC(1_200_000), .BAUD_RATE(100_000), .DATA_BITS(7)) dut7 (
        .clk   (clk),
        .reset (reset),
        .bus   (if7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic get_txd(input bit use7);
        return use7 ? if7.txd : if8.txd;
    endfunction

    function automatic logic get_busy(input bit use7);
        return use7 ? if7.busy : if8.busy;
    endfunction

    function automatic logic get_ready(input bit use7);
        return use7 ? if7.tx_ready : if8.tx_ready;
    endfunction

    // Reference frame: list of line levels, one entry per bit period
    function automatic void build(input logic [8:0] w, input int nb,
                                  input logic [1:0] pm, input bit ts);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int k = 0; k < nb; k++) begin
            exp_q.push_back(w[k]);
            if (w[k]) ones++;
        end
        if (pm == PAR_EVEN) exp_q.push_back(bit'(ones % 2));
        if (pm == PAR_ODD)  exp_q.push_back(bit'(1 - ones % 2));
        exp_q.push_back(1'b1);
        if (ts) exp_q.push_back(1'b1);
    endfunction

    task automatic drive(input bit use7, input logic [8:0] w, input logic [1:0] pm,
                         input bit ts, input logic v);
        if (use7) begin
            if7.tx_data     = w[6:0];
            if7.parity_mode = pm;
            if7.two_stop    = ts;
            if7.tx_valid    = v;
        end else begin
            if8.tx_data     = w[7:0];
            if8.parity_mode = pm;
            if8.two_stop    = ts;
            if8.tx_valid    = v;
        end
    endtask

    // One word from an idle transmitter; optional mid-frame option change or reset
    task automatic send_frame(input bit use7, input logic [8:0] w, input logic [1:0] pm,
                              input bit ts, input int chg_at, input logic [1:0] chg_pm,
                              input int rst_at);
        int len;
        exp_q.delete();
        build(w, use7 ? 7 : 8, pm, ts);
        len = exp_q.size() * DIV;
        drive(use7, w, pm, ts, 1'b1);
        chk("ready_at_transfer", get_ready(use7), 1'b1);
        step();
        chk("ready_n1", get_ready(use7), 1'b0);
        chk("txd_n1", get_txd(use7), 1'b1);
        drive(use7, w, pm, ts, 1'b0);
        step();
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_txd", get_txd(use7), 1'b1);
                chk("rst_busy", get_busy(use7), 1'b0);
                chk("rst_ready", get_ready(use7), 1'b1);
                return;
            end
            chk("frame_txd", get_txd(use7), exp_q[i / DIV]);
            chk("frame_busy", get_busy(use7), 1'b1);
            chk("frame_ready", get_ready(use7), 1'b1);
            if (i == chg_at) begin
                if (use7) if7.parity_mode = chg_pm;
                else      if8.parity_mode = chg_pm;
            end
            step();
        end
        chk("after_busy", get_busy(use7), 1'b0);
        chk("after_txd", get_txd(use7), 1'b1);
        chk("after_ready", get_ready(use7), 1'b1);
    endtask

    initial begin
        logic [8:0] w;
        logic [1:0] pm;
        bit         ts;
        bit         u7;
        int         gap;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 9'h000, PAR_NONE, 1'b0, 1'b0);
        drive(1'b1, 9'h000, PAR_NONE, 1'b0, 1'b0);
        step();
        step();

        // Reset state of both transmitters
        chk("reset_txd8", get_txd(1'b0), 1'b1);
        chk("reset_busy8", get_busy(1'b0), 1'b0);
        chk("reset_ready8", get_ready(1'b0), 1'b1);
        chk("reset_txd7", get_txd(1'b1), 1'b1);
        chk("reset_busy7", get_busy(1'b1), 1'b0);
        chk("reset_ready7", get_ready(1'b1), 1'b1);
        reset = 1'b0;
        step();
        step();

        // Single word, no parity, one stop
        send_frame(1'b0, 9'h055, PAR_NONE, 1'b0, -1, PAR_NONE, -1);

        // Parity even / odd on 0x03
        send_frame(1'b0, 9'h003, PAR_EVEN, 1'b0, -1, PAR_NONE, -1);
        send_frame(1'b0, 9'h003, PAR_ODD, 1'b0, -1, PAR_NONE, -1);

        // Seven data bits, two stop bits
        send_frame(1'b1, 9'h07F, PAR_NONE, 1'b1, -1, PAR_NONE, -1);

        // Back-to-back: valid held high across two words
        exp_q.delete();
        build(9'h0A5, 8, PAR_NONE, 1'b0);
        build(9'h03C, 8, PAR_NONE, 1'b0);
        drive(1'b0, 9'h0A5, PAR_NONE, 1'b0, 1'b1);
        step();
        chk("b2b_ready_n1", get_ready(1'b0), 1'b0);
        if8.tx_data = 8'h3C;
        step();
        for (int i = 0; i < 2 * 10 * DIV; i++) begin
            chk("b2b_txd", get_txd(1'b0), exp_q[i / DIV]);
            chk("b2b_busy", get_busy(1'b0), 1'b1);
            chk("b2b_ready", get_ready(1'b0), (i == 0) || (i >= 10 * DIV));
            if (i == 1) if8.tx_valid = 1'b0;
            step();
        end
        chk("b2b_end_busy", get_busy(1'b0), 1'b0);
        chk("b2b_end_txd", get_txd(1'b0), 1'b1);

        // Option change during data bits does not touch the frame in flight
        w = 9'($urandom);
        send_frame(1'b0, w, PAR_NONE, 1'b0, 40, PAR_ODD, -1);
        w = 9'($urandom);
        send_frame(1'b0, w, if8.parity_mode, 1'b0, -1, PAR_NONE, -1);

        // Randomized frames on both widths
        for (int k = 0; k < 8; k++) begin
            u7  = (k % 4 == 3);
            w   = 9'($urandom);
            pm  = 2'($urandom_range(0, 3));
            ts  = 1'($urandom_range(0, 1));
            gap = $urandom_range(0, 3);
            repeat (gap) step();
            send_frame(u7, w, pm, ts, -1, PAR_NONE, -1);
        end

        // Asynchronous reset during data bit 4, then a clean frame
        send_frame(1'b0, 9'h0C6, PAR_EVEN, 1'b1, 5 * DIV + 4, PAR_NONE, 5 * DIV + 4);
        #2 reset = 1'b0;
        step();
        step();
        chk("post_rst_busy", get_busy(1'b0), 1'b0);
        chk("post_rst_txd", get_txd(1'b0), 1'b1);
        send_frame(1'b0, 9'h081, PAR_NONE, 1'b0, -1, PAR_NONE, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ext.md
# uart_tx_ext

Parametrised UART transmitter for iCE40 designs. Serialises DATA_BITS-wide words with optional even/odd parity and one or two stop bits at a fixed baud rate. Words are accepted over a valid/ready handshake into a one-entry holding register, so back-to-back frames go out with no idle gap. It sits between any byte-stream producer (FIFO, command encoder) and the `txd` pin.

## Interface

**Parameters**
- `F_OSC`, default 12_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
  - `DIV = F_OSC / BAUD_RATE` (integer division); legal range is DIV ≥ 4.
- `DATA_BITS`, default 8: word width; legal range 5..9.

**Ports**
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `tx_data`  in  DATA_BITS: word to send, LSB first.
- `tx_valid`  in  1: producer has a word.
- `tx_ready`  out  1: holding register is empty.
  - A word transfers on a cycle where `tx_valid & tx_ready`.
- `parity_mode`  in  2: 00 none, 01 even, 10 odd, 11 treated as none. Sampled at transfer.
- `two_stop`  in  1: 0 → one stop bit, 1 → two stop bits. Sampled at transfer.
- `busy`  out  1: a frame is on the line (any state other than IDLE).
- `txd`  out  1: serial output, idle high.

## Operation

**Holding register**
- The holding register stores the word and the `parity_mode`/`two_stop` values sampled with it.
- It is written on transfer and drained when the FSM loads a frame.
- `tx_ready = !hold_full`.

**FSM states:** IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `hold_full`: load the shift register, bit counter and frame config; clear `hold_full`.
- START: `txd = 0` for DIV cycles → DATA.
- DATA: `txd = shift[0]`. Shift right every DIV cycles. After DATA_BITS bits, go to PARITY if parity is enabled, else STOP.
- PARITY: `txd = ^data` for even, `~^data` for odd, computed over the DATA_BITS bits at load time. Lasts DIV cycles → STOP.
- STOP: `txd = 1` for DIV cycles, or 2·DIV cycles when `two_stop`.
  - At the end of STOP: if `hold_full`, go directly to START (loading as in IDLE → START); else go to IDLE.

**Baud counter**
- Counts DIV-1 down to 0. A tick at 0 ends the current bit.
- It is restarted on every frame load, so every bit, including the first, lasts exactly DIV cycles.

**Simultaneous events**
- A transfer on the same cycle the FSM drains the holding register is legal: the new word lands in the now-empty register. `tx_ready` is still the registered pre-drain value (0), so this case only arises if the combinational form is chosen. Decision: `tx_ready` is registered-free combinational from `hold_full` only; drain and fill in the same cycle do not occur.
- Changing `parity_mode`/`two_stop` mid-frame has no effect on the frame in flight.

**Reset (asynchronous, any time, including mid-frame)**
- Outputs: `txd = 1`, `busy = 0`, `tx_ready = 1`.
- State: FSM in IDLE, `hold_full = 0`, counters cleared.
- A partially sent frame is abandoned.

## Timing

- Transfer at cycle N with FSM idle:
  - `hold_full` is set at N+1.
  - FSM enters START at N+2, so `txd` falls at N+2.
  - `tx_ready` is low for cycle N+1 only and returns high at N+2.
- Frame length in cycles is DIV·(1 + DATA_BITS + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- `busy` rises with START and falls on the cycle after the last stop tick when no word is pending.
- Back-to-back transfer: the next start bit begins on the cycle immediately after the last stop cycle, with zero idle cycles.
- Throughput is one word per frame time. At most one word waits while another is being sent.

## Structure

- Shared package `uart_pkg` holds:
  - the state encoding: IDLE, START, DATA, PARITY, STOP;
  - the parity-mode constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - a `uart_div(F_OSC, BAUD_RATE)` constant function.
  - The package is shared with a future `uart_rx_ext`.
- One sub-module, `uart_baud_gen`:
  - parameter DIV;
  - ports `clk`, `reset`, `restart`, `en` → `tick`;
  - down-counter with synchronous restart.

## Test plan

Bench settings: F_OSC=1_200_000, BAUD_RATE=100_000 (DIV=12), DATA_BITS=8 unless stated.

- **Single word:** send 0x55, parity none, one stop → `txd` shows 0,1,0,1,0,1,0,1,0,1. Each bit is 12 cycles (120 cycles total) and `busy` drops afterwards.
- **Parity:** send 0x03 with even → parity bit 0; send 0x03 with odd → parity bit 1. Frames are 132 cycles each.
- **Two stop bits with DATA_BITS=7:** send 0x7F → frame is 1+7+2 bits, 120 cycles, and the last 24 cycles are high.
- **Back-to-back:** hold `tx_valid` with 0xA5 then 0x3C → `tx_ready` drops and recovers once per word. The second start bit immediately follows the first stop bit with 0 idle cycles, and 240 contiguous cycles are checked.
- **Config change mid-frame:** switch `parity_mode` to odd during the DATA bits of a no-parity frame → the in-flight frame has no parity bit, and the next accepted frame uses the new setting.
- **Reset mid-frame:** assert `reset` asynchronously during bit 4 → `txd=1`, `busy=0` and `tx_ready=1` immediately. After release, a new word 0x81 sends a clean frame.
